// File: rtl/seletor_destino_pipeline_pkg.sv
// Shared processor definitions: reg_dst destination-mode encodings and default register-index width.
// Pure declarations, no logic; imported by the destination selector and its stage register.
package pacote_processador;

    localparam int REG_WIDTH_PADRAO = 5;

    typedef enum logic [1:0] {
        DST_RD     = 2'b00,
        DST_RT     = 2'b01,
        DST_RA     = 2'b10,
        DST_NENHUM = 2'b11
    } modo_destino_t;

endpackage

// File: rtl/seletor_destino_pipeline_if.sv
// Decoder-side bundle of the destination selector: field/mode inputs, pipeline control and the hazard outputs.
// master = decoder/control driving the fields, slave = the selector producing stage and conflict information.
interface seletor_destino_pipeline_if #(
    parameter int REG_WIDTH = 5,
    parameter int DEPTH     = 3
);
    localparam int DIST_WIDTH = $clog2(DEPTH + 1);

    logic [REG_WIDTH-1:0]       reg_t;
    logic [REG_WIDTH-1:0]       reg_d;
    logic [1:0]                 reg_dst;
    logic                       escreve_reg;
    logic                       avanca;
    logic                       descarta;
    logic [REG_WIDTH-1:0]       fonte_s;
    logic [REG_WIDTH-1:0]       fonte_t;
    logic [REG_WIDTH-1:0]       destino_escolhido;
    logic [DEPTH*REG_WIDTH-1:0] destino_estagio;
    logic [DEPTH-1:0]           valido_estagio;
    logic                       conflito_s;
    logic                       conflito_t;
    logic [DIST_WIDTH-1:0]      distancia_s;
    logic [DIST_WIDTH-1:0]      distancia_t;

    modport master (
        output reg_t, reg_d, reg_dst, escreve_reg, avanca, descarta, fonte_s, fonte_t,
        input  destino_escolhido, destino_estagio, valido_estagio,
               conflito_s, conflito_t, distancia_s, distancia_t
    );

    modport slave (
        input  reg_t, reg_d, reg_dst, escreve_reg, avanca, descarta, fonte_s, fonte_t,
        output destino_escolhido, destino_estagio, valido_estagio,
               conflito_s, conflito_t, distancia_s, distancia_t
    );
endinterface

// File: rtl/seletor_destino_pipeline_estagio.sv
// One in-flight destination slot (valid + register index); loads on habilita, else limpa drops only the valid bit.
// One cycle from habilita to visible contents; holds when neither control is set.
module estagio_destino #(
    parameter int REG_WIDTH = pacote_processador::REG_WIDTH_PADRAO
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 habilita,
    input  logic                 limpa,
    input  logic                 valido_novo,
    input  logic [REG_WIDTH-1:0] destino_novo,
    output logic                 valido,
    output logic [REG_WIDTH-1:0] destino
);

    always_ff @(posedge clock) begin
        if (reset) begin
            valido  <= 1'b0;
            destino <= '0;
        end else if (habilita) begin
            valido  <= valido_novo;
            destino <= destino_novo;
        end else if (limpa) begin
            valido  <= 1'b0;
        end
    end

endmodule

// File: rtl/seletor_destino_pipeline.sv
// Picks the writeback register (rd/rt/link/none), tracks it through DEPTH stages and flags RAW hits for rs/rt.
// Stage 0 shows an entry one cycle after the accepting avanca edge; avanca=0 stalls, descarta bubbles stage 0.
module seletor_destino_pipeline
    import pacote_processador::*;
#(
    parameter int REG_WIDTH = REG_WIDTH_PADRAO,
    parameter int DEPTH     = 3,
    parameter int RA_INDEX  = 31
) (
    input  logic                          clock,
    input  logic                          reset,
    seletor_destino_pipeline_if.slave     bus
);

    localparam int DIST_WIDTH = $clog2(DEPTH + 1);

    logic [REG_WIDTH-1:0]  escolhido;
    logic                  novo_valido;
    logic [DEPTH-1:0]      valido;
    logic [REG_WIDTH-1:0]  destino [DEPTH];
    logic                  conflito_s_c;
    logic                  conflito_t_c;
    logic [DIST_WIDTH-1:0] distancia_s_c;
    logic [DIST_WIDTH-1:0] distancia_t_c;

    always_comb begin
        escolhido = '0;
        case (modo_destino_t'(bus.reg_dst))
            DST_RD:     escolhido = bus.reg_d;
            DST_RT:     escolhido = bus.reg_t;
            DST_RA:     escolhido = REG_WIDTH'(RA_INDEX);
            DST_NENHUM: escolhido = '0;
            default:    escolhido = '0;
        endcase
    end

    // r0 is hardwired to zero, so writing it is never a real hazard source
    assign novo_valido = bus.escreve_reg
                       & (modo_destino_t'(bus.reg_dst) != DST_NENHUM)
                       & (escolhido != '0)
                       & ~bus.descarta;

    for (genvar i = 0; i < DEPTH; i++) begin : g_estagio
        if (i == 0) begin : g_entrada
            estagio_destino #(.REG_WIDTH(REG_WIDTH)) u_estagio (
                .clock        (clock),
                .reset        (reset),
                .habilita     (bus.avanca),
                .limpa        (bus.descarta),
                .valido_novo  (novo_valido),
                .destino_novo (escolhido),
                .valido       (valido[i]),
                .destino      (destino[i])
            );
        end else begin : g_interno
            estagio_destino #(.REG_WIDTH(REG_WIDTH)) u_estagio (
                .clock        (clock),
                .reset        (reset),
                .habilita     (bus.avanca),
                .limpa        (1'b0),
                .valido_novo  (valido[i-1]),
                .destino_novo (destino[i-1]),
                .valido       (valido[i]),
                .destino      (destino[i])
            );
        end
        assign bus.destino_estagio[i*REG_WIDTH +: REG_WIDTH] = destino[i];
    end

    // Scan oldest to youngest so the youngest match overwrites the distance
    always_comb begin
        conflito_s_c  = 1'b0;
        conflito_t_c  = 1'b0;
        distancia_s_c = '0;
        distancia_t_c = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valido[i] && (destino[i] == bus.fonte_s) && (bus.fonte_s != '0)) begin
                conflito_s_c  = 1'b1;
                distancia_s_c = DIST_WIDTH'(i + 1);
            end
            if (valido[i] && (destino[i] == bus.fonte_t) && (bus.fonte_t != '0)) begin
                conflito_t_c  = 1'b1;
                distancia_t_c = DIST_WIDTH'(i + 1);
            end
        end
    end

    assign bus.destino_escolhido = escolhido;
    assign bus.valido_estagio    = valido;
    assign bus.conflito_s        = conflito_s_c;
    assign bus.conflito_t        = conflito_t_c;
    assign bus.distancia_s       = distancia_s_c;
    assign bus.distancia_t       = distancia_t_c;

endmodule

// File: tb/tb_seletor_destino_pipeline.sv
// Bench for seletor_destino_pipeline: directed scenarios plus randomized traffic against a queue-based model.
module tb_seletor_destino_pipeline;

    localparam int RW = 5;
    localparam int DP = 3;
    localparam int RA = 31;

    typedef struct {
        bit valid;
        int dest;
    } entrada_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;

    entrada_t pipe[$];

    seletor_destino_pipeline_if #(.REG_WIDTH(RW), .DEPTH(DP)) bus ();

    seletor_destino_pipeline #(.REG_WIDTH(RW), .DEPTH(DP), .RA_INDEX(RA)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    function automatic int modelo_escolhido();
        int m = int'(bus.reg_dst);
        if (m == 3) return 0;
        if (m == 2) return RA;
        if (m == 1) return int'(bus.reg_t);
        return int'(bus.reg_d);
    endfunction

    function automatic int modelo_distancia(input int fonte);
        if (fonte == 0) return 0;
        foreach (pipe[i]) begin
            if (pipe[i].valid && pipe[i].dest == fonte) return i + 1;
        end
        return 0;
    endfunction

    task automatic modelo_reset();
        pipe.delete();
        for (int i = 0; i < DP; i++) pipe.push_back('{valid: 1'b0, dest: 0});
    endtask

    // Apply the rules for one rising edge using the inputs held across it
    task automatic modelo_borda();
        entrada_t novo;
        if (reset) begin
            modelo_reset();
        end else if (bus.avanca) begin
            novo.dest  = modelo_escolhido();
            novo.valid = bus.escreve_reg && (bus.reg_dst != 2'b11) && (novo.dest != 0) && !bus.descarta;
            pipe.push_front(novo);
            void'(pipe.pop_back());
        end else if (bus.descarta) begin
            pipe[0].valid = 1'b0;
        end
    endtask

    task automatic confere_tudo(input string tag);
        logic [DP*RW-1:0] exp_dest = '0;
        logic [DP-1:0]    exp_val  = '0;
        int ds, dt;
        #1;
        for (int i = 0; i < DP; i++) begin
            exp_dest[i*RW +: RW] = RW'(pipe[i].dest);
            exp_val[i]           = pipe[i].valid;
        end
        ds = modelo_distancia(int'(bus.fonte_s));
        dt = modelo_distancia(int'(bus.fonte_t));
        verifica({tag, ".escolhido"}, 32'(bus.destino_escolhido), 32'(modelo_escolhido()));
        verifica({tag, ".destino_estagio"}, 32'(bus.destino_estagio), 32'(exp_dest));
        verifica({tag, ".valido_estagio"}, 32'(bus.valido_estagio), 32'(exp_val));
        verifica({tag, ".conflito_s"}, 32'(bus.conflito_s), 32'(ds != 0));
        verifica({tag, ".conflito_t"}, 32'(bus.conflito_t), 32'(dt != 0));
        verifica({tag, ".distancia_s"}, 32'(bus.distancia_s), 32'(ds));
        verifica({tag, ".distancia_t"}, 32'(bus.distancia_t), 32'(dt));
    endtask

    // Inputs are set around the falling edge; check, cross one rising edge, return at the next falling edge
    task automatic ciclo(input string tag);
        confere_tudo(tag);
        @(posedge clock);
        modelo_borda();
        @(negedge clock);
    endtask

    task automatic entradas_aleatorias();
        bus.reg_t       = RW'($urandom);
        bus.reg_d       = RW'($urandom);
        bus.reg_dst     = 2'($urandom);
        bus.escreve_reg = 1'($urandom);
        bus.avanca      = 1'($urandom);
        bus.descarta    = 1'($urandom);
        bus.fonte_s     = RW'($urandom);
        bus.fonte_t     = RW'($urandom);
    endtask

    task automatic escreve(input int rd, input string tag);
        bus.reg_d       = RW'(rd);
        bus.reg_dst     = 2'b00;
        bus.escreve_reg = 1'b1;
        bus.avanca      = 1'b1;
        bus.descarta    = 1'b0;
        ciclo(tag);
    endtask

    task automatic parado();
        bus.avanca      = 1'b0;
        bus.descarta    = 1'b0;
        bus.escreve_reg = 1'b0;
    endtask

    initial begin : estimulo
        logic [31:0] modos_esperados [4];
        modos_esperados = '{32'd9, 32'd8, 32'd31, 32'd0};
        modelo_reset();

        // Reset held two cycles with random inputs
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            entradas_aleatorias();
            @(posedge clock);
            modelo_borda();
            @(negedge clock);
        end
        reset = 1'b0;
        parado();
        bus.fonte_s = RW'($urandom);
        bus.fonte_t = RW'($urandom);
        #1;
        verifica("reset.valido", 32'(bus.valido_estagio), 32'd0);
        verifica("reset.destino", 32'(bus.destino_estagio), 32'd0);
        verifica("reset.conflito_s", 32'(bus.conflito_s), 32'd0);
        verifica("reset.distancia_t", 32'(bus.distancia_t), 32'd0);
        confere_tudo("reset");

        // Mode sweep
        bus.reg_t = RW'(8);
        bus.reg_d = RW'(9);
        for (int m = 0; m < 4; m++) begin
            bus.reg_dst = 2'(m);
            #1;
            verifica($sformatf("modo%0d", m), 32'(bus.destino_escolhido), modos_esperados[m]);
        end

        // Three writes fill the pipe: 11 youngest, 9 oldest
        escreve(9, "w9");
        escreve(10, "w10");
        escreve(11, "w11");
        parado();
        bus.fonte_s = RW'(9);
        bus.fonte_t = RW'(11);
        #1;
        verifica("tres.destino", 32'(bus.destino_estagio), (32'd9 << 10) | (32'd10 << 5) | 32'd11);
        verifica("tres.valido", 32'(bus.valido_estagio), 32'b111);
        verifica("tres.conflito_s", 32'(bus.conflito_s), 32'd1);
        verifica("tres.distancia_s", 32'(bus.distancia_s), 32'd3);
        verifica("tres.conflito_t", 32'(bus.conflito_t), 32'd1);
        verifica("tres.distancia_t", 32'(bus.distancia_t), 32'd1);

        // Writing r0 never creates a valid entry, and a zero source never conflicts
        escreve(0, "w0");
        parado();
        bus.fonte_s = RW'(0);
        #1;
        verifica("r0.valido0", 32'(bus.valido_estagio[0]), 32'd0);
        verifica("r0.conflito_s", 32'(bus.conflito_s), 32'd0);

        // Stall, then flush of stage 0 while stalled
        escreve(12, "w12");
        parado();
        for (int c = 0; c < 3; c++) ciclo("stall");
        verifica("stall.destino", 32'(bus.destino_estagio), (32'd11 << 10) | (32'd0 << 5) | 32'd12);
        verifica("stall.valido", 32'(bus.valido_estagio), 32'b101);
        bus.descarta = 1'b1;
        ciclo("flush");
        bus.descarta = 1'b0;
        #1;
        verifica("flush.valido", 32'(bus.valido_estagio), 32'b100);
        verifica("flush.destino", 32'(bus.destino_estagio), (32'd11 << 10) | (32'd0 << 5) | 32'd12);
        escreve(13, "w13");
        parado();
        #1;
        verifica("bolha.valido", 32'(bus.valido_estagio), 32'b001);
        verifica("bolha.destino1", 32'(bus.destino_estagio[RW +: RW]), 32'd12);

        // Youngest match wins, then reset clears everything
        escreve(7, "w7a");
        escreve(5, "w5");
        escreve(7, "w7b");
        parado();
        bus.fonte_s = RW'(7);
        bus.fonte_t = RW'(5);
        #1;
        verifica("jovem.distancia_s", 32'(bus.distancia_s), 32'd1);
        verifica("jovem.distancia_t", 32'(bus.distancia_t), 32'd2);
        reset = 1'b1;
        ciclo("rst_meio");
        reset = 1'b0;
        #1;
        verifica("rst_meio.valido", 32'(bus.valido_estagio), 32'd0);
        verifica("rst_meio.conflito_s", 32'(bus.conflito_s), 32'd0);

        // Randomized traffic; sources biased toward destinations in flight
        for (int c = 0; c < 400; c++) begin
            entradas_aleatorias();
            bus.avanca = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) bus.fonte_s = RW'(pipe[$urandom_range(0, DP - 1)].dest);
            if ($urandom_range(0, 1) == 1) bus.fonte_t = RW'(pipe[$urandom_range(0, DP - 1)].dest);
            if ($urandom_range(0, 3) == 0) bus.reg_d = RW'(bus.fonte_s);
            reset = ($urandom_range(0, 39) == 0);
            ciclo("aleat");
        end
        reset = 1'b0;
        confere_tudo("final");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
